// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register bank: FSM state encoding,
// default parameter values and the zero word used by the clear sweep.
package reg_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_BYPASS   = 1;
  localparam int DEF_ZERO_REG = 0;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/reg_bank_ram.sv
// Storage array for reg_bank: one write port and two synchronous read ports.
// A read in the same cycle as a write to the same word returns the old contents.
module reg_bank_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clkout,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or read registers; the owner zeroes words with a
  // sweep and masks read data until a valid read, so this maps onto plain RAM.
  always_ff @(posedge clkout) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Two-read/one-write register bank with a DEPTH-cycle clear sweep, optional
// write-first forwarding and an optional hardwired-zero word 0.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic              clkout,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

  logic              idle;
  logic              wr_ok;
  logic              rd_ok;
  logic              rd_a_live, rd_b_live;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q_a, ram_q_b;

  logic              zero_a, zero_b;
  logic              fwd_a, fwd_b;
  logic [DATA_W-1:0] fwd_data;

  // A word is live when it exists and is not the hardwired zero register.
  function automatic logic is_live(input logic [ADDR_W-1:0] addr);
    logic in_range;
    in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    return in_range && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  assign idle      = (state == IDLE);
  assign busy      = (state == CLEAR);
  assign wr_ok     = idle && wr_en && is_live(wr_addr);
  assign rd_ok     = idle && rd_en;
  assign rd_a_live = is_live(rd_addr_a);
  assign rd_b_live = is_live(rd_addr_b);

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clkout) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // The sweep owns the write port while busy; reset blocks all array traffic.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    ram_re    = 1'b0;
    if (!rst) begin
      ram_re = rd_ok;
      if (busy) begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr;
        ram_wdata = DATA_W'(ZERO_WORD);
      end else begin
        ram_we = wr_ok;
      end
    end
  end

  reg_bank_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clkout (clkout),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .re     (ram_re),
    .raddr_a(rd_addr_a),
    .raddr_b(rd_addr_b),
    .rdata_a(ram_q_a),
    .rdata_b(ram_q_b)
  );

  // Per-port selectors captured alongside the RAM read; they hold with it when idle.
  always_ff @(posedge clkout) begin
    if (rst) begin
      rd_valid <= 1'b0;
      zero_a   <= 1'b1;
      zero_b   <= 1'b1;
      fwd_a    <= 1'b0;
      fwd_b    <= 1'b0;
      fwd_data <= '0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        zero_a   <= !rd_a_live;
        zero_b   <= !rd_b_live;
        fwd_a    <= (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_a);
        fwd_b    <= (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_b);
        fwd_data <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data_a = ram_q_a;
    rd_data_b = ram_q_b;
    if (zero_a) begin
      rd_data_a = '0;
    end else if (fwd_a) begin
      rd_data_a = fwd_data;
    end
    if (zero_b) begin
      rd_data_b = '0;
    end else if (fwd_b) begin
      rd_data_b = fwd_data;
    end
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: address width.
REQ-002 SHALL have parameter DATA_W, default 32: word width.
REQ-003 SHALL have parameter DEPTH, default 32: number of words, 2 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = write-first forwarding, 0 = read-old.
REQ-005 SHALL have parameter ZERO_REG, default 0: 1 = word 0 hardwired to zero.
REQ-006 clkout  input  1  sole clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_addr  input  ADDR_W  write address.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 rd_en  input  1  read request, both ports.
REQ-012 rd_addr_a / rd_addr_b  input  ADDR_W each  read addresses.
REQ-013 rd_data_a / rd_data_b  output  DATA_W each  registered read data.
REQ-014 rd_valid  output  1  high for one cycle when rd_data_* updated by an accepted read.
REQ-015 clr_req  input  1  request a full-array clear.
REQ-016 busy  output  1  clear sweep in progress; requests ignored.

Function
REQ-017 SHALL implement FSM states IDLE and CLEAR; CLEAR holds a sweep counter clr_ptr, width ADDR_W.
REQ-018 IDLE -> CLEAR on clr_req=1; clr_ptr loads 0.
REQ-019 In CLEAR, word clr_ptr SHALL be written 0 each cycle and clr_ptr incremented; exit to IDLE in the cycle clearing DEPTH-1, so a sweep lasts exactly DEPTH cycles.
REQ-020 busy SHALL be 1 exactly while state=CLEAR.
REQ-021 While busy, wr_en, rd_en and clr_req SHALL be ignored; rd_data_* hold; rd_valid=0.
REQ-022 In IDLE, wr_en=1 SHALL write wr_data to wr_addr at the clock edge.
REQ-023 Read latency SHALL be 1 cycle: rd_en=1 in IDLE at edge N gives rd_data_a/b and rd_valid=1 after edge N; rd_valid=0 otherwise.
REQ-024 With rd_en=0, rd_data_a/b SHALL hold their last values.
REQ-025 Same-cycle write and read to same address: BYPASS=1 returns wr_data; BYPASS=0 returns the prior contents.
REQ-026 rd_addr_a = rd_addr_b SHALL return identical data on both ports.
REQ-027 ZERO_REG=1: writes to address 0 discarded; reads of address 0 return 0, including bypass case.
REQ-028 Address >= DEPTH: write discarded; read returns 0; no bypass.
REQ-029 clr_req and wr_en in the same IDLE cycle: the write SHALL be performed, then the sweep SHALL start next cycle and erase it.

Reset
REQ-030 rst=1 SHALL force state CLEAR with clr_ptr=0, rd_data_a/b=0, rd_valid=0, busy=1 on the next edge; the array is zeroed by the sweep, not by reset fan-out.
REQ-031 rst asserted mid-sweep SHALL restart the sweep at 0.
REQ-032 rst SHALL have priority over clr_req, wr_en and rd_en.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, default parameter constants, and a zero-word constant.
REQ-034 Storage array SHALL be a sub-module reg_bank_ram: one write port, two synchronous read ports, no reset; FSM, bypass and zero/range logic stay in reg_bank.

Verification
REQ-035 Reset: rst 1 cycle -> busy=1 for 32 cycles, then 0; reads of addresses 0..31 all return 0.
REQ-036 Write/read: write 0xDEADBEEF to 5, next cycle rd_en with a=5, b=6 -> one cycle later rd_data_a=0xDEADBEEF, rd_data_b=0, rd_valid=1.
REQ-037 Bypass: 0x11111111 in address 3; same cycle write 0x22222222 to 3 and read a=3 -> BYPASS=1 gives 0x22222222; BYPASS=0 gives 0x11111111.
REQ-038 ZERO_REG=1: write 0xFFFFFFFF to 0 with simultaneous read of 0 -> 0; later read of 0 -> 0.
REQ-039 Clear with traffic: fill 0..31 with index value; clr_req; drive wr_en and rd_en during sweep -> rd_valid stays 0, writes lost, all words 0 after 32 cycles.
REQ-040 Mid-sweep reset: rst at sweep cycle 10 -> busy stays 1 for 32 more cycles; DEPTH=20, ADDR_W=5 read of 25 -> 0.
